pc_trace_buffer: RTL and testbench

- Synthesizable, parametrised trace recorder for the multicycle processing unit.
- Logs one (PC, control state) entry on every control-FSM state transition into a circular buffer.
- Optional PC trigger freezes the buffer after a post-trigger window.
- Read port lets the simulation top or a debug port drain entries oldest-first; it replaces free-running console monitoring of PC/state.

---
 rtl/pc_trace_buffer.sv | 105 ++++++++++
 tb/tb_pc_trace_buffer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pc_trace_buffer.sv
// pc_trace_buffer: circular trace of (PC, control state) entries logged on every control-FSM transition
// Ports: clk/Reset (sync, active-high); PCIn/StateIn traced values; TrigEn/TrigPC PC trigger;
//        Rearm leaves FROZEN; RdReq pops oldest entry onto RdValid/RdPC/RdState/RdStamp;
//        Count entries held; Frozen trace stopped; Overflow sticky unread-entry overwrite.
// Optional: define PC_TRACE_STAMP_EN for the 32-bit cycle stamp counter and per-entry stamps.
module pc_trace_buffer #(
    parameter int XLEN    = 64,
    parameter int STATE_W = 5,
    parameter int DEPTH   = 16,
    parameter int POST    = DEPTH / 2
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic [XLEN-1:0]          PCIn,
    input  logic [STATE_W-1:0]       StateIn,
    input  logic                     TrigEn,
    input  logic [XLEN-1:0]          TrigPC,
    input  logic                     Rearm,
    input  logic                     RdReq,
    output logic                     RdValid,
    output logic [XLEN-1:0]          RdPC,
    output logic [STATE_W-1:0]       RdState,
    output logic [31:0]              RdStamp,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Frozen,
    output logic                     Overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] RUN = 2'd0, POSTTRIG = 2'd1, FROZEN = 2'd2;
    logic [1:0]         fsm;
    logic [XLEN-1:0]    mem_pc [DEPTH];
    logic [STATE_W-1:0] mem_st [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr, post_cnt;
    logic [STATE_W-1:0] state_q;
    logic               primed, log_ev, pop, full, hit;
    // Primed forces a log in the first cycle after reset so the starting state is captured
    assign log_ev = fsm != FROZEN && (!primed || StateIn != state_q);
    assign pop    = RdReq && Count != '0;
    assign full   = Count == CW'(DEPTH);
    assign hit    = TrigEn && PCIn == TrigPC;
    assign Frozen = fsm == FROZEN;
    always_ff @(posedge clk) begin
        if (!Reset && log_ev) begin
            mem_pc[wr_ptr] <= PCIn;
            mem_st[wr_ptr] <= StateIn;
        end
    end
    always_ff @(posedge clk) begin
        if (Reset) begin
            fsm      <= RUN;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            post_cnt <= '0;
            state_q  <= '0;
            primed   <= 1'b0;
            Count    <= '0;
            RdValid  <= 1'b0;
            RdPC     <= '0;
            RdState  <= '0;
            Overflow <= 1'b0;
        end else begin
            state_q <= StateIn;
            primed  <= 1'b1;
            RdValid <= pop;
            if (pop) begin
                RdPC    <= mem_pc[rd_ptr];
                RdState <= mem_st[rd_ptr];
            end
            if (log_ev) wr_ptr <= wr_ptr + AW'(1);
            // A log into a full buffer drops the oldest entry, so the read side advances too
            if (pop || (log_ev && full)) rd_ptr <= rd_ptr + AW'(1);
            if (log_ev && full && !pop) Overflow <= 1'b1;
            if (log_ev && !pop && !full) Count <= Count + CW'(1);
            else if (pop && !log_ev) Count <= Count - CW'(1);
            if (fsm == RUN && log_ev && hit) begin
                fsm      <= POST == 0 ? FROZEN : POSTTRIG;
                post_cnt <= AW'(POST);
            end else if (fsm == POSTTRIG && log_ev) begin
                post_cnt <= post_cnt - AW'(1);
                if (post_cnt == AW'(1)) fsm <= FROZEN;
            end else if (fsm == FROZEN && Rearm) begin
                fsm <= RUN;
            end
        end
    end
`ifdef PC_TRACE_STAMP_EN
    logic [31:0] stamp;
    logic [31:0] mem_stamp [DEPTH];
    always_ff @(posedge clk) begin
        if (!Reset && log_ev) mem_stamp[wr_ptr] <= stamp;
    end
    always_ff @(posedge clk) begin
        if (Reset) begin
            stamp   <= '0;
            RdStamp <= '0;
        end else begin
            stamp <= stamp + 32'd1;
            if (pop) RdStamp <= mem_stamp[rd_ptr];
        end
    end
`else
    assign RdStamp = '0;
`endif
endmodule

// File: tb/tb_pc_trace_buffer.sv
// tb_pc_trace_buffer: directed scoreboard bench for pc_trace_buffer (DEPTH 16, POST 8)
module tb_pc_trace_buffer;
    typedef struct {
        logic [63:0] pc;
        logic [4:0]  st;
        logic [31:0] stamp;
    } ent_t;
    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [63:0] PCIn = '0;
    logic [4:0]  StateIn = '0;
    logic        TrigEn = 1'b0;
    logic [63:0] TrigPC = '0;
    logic        Rearm = 1'b0;
    logic        RdReq = 1'b0;
    logic        RdValid;
    logic [63:0] RdPC;
    logic [4:0]  RdState;
    logic [31:0] RdStamp;
    logic [4:0]  Count;
    logic        Frozen;
    logic        Overflow;
    int          vecs = 0;
    int          errs = 0;
    ent_t        m_q[$];
    ent_t        sb_q[$];
    int          m_mode = 0;
    int          m_pcnt = 0;
    bit          m_primed = 0;
    bit          m_ovf = 0;
    logic [4:0]  m_stq = '0;
    logic [31:0] m_stamp = '0;

    pc_trace_buffer #(.XLEN(64), .STATE_W(5), .DEPTH(16), .POST(8)) dut (
        .clk(clk), .Reset(Reset), .PCIn(PCIn), .StateIn(StateIn), .TrigEn(TrigEn),
        .TrigPC(TrigPC), .Rearm(Rearm), .RdReq(RdReq), .RdValid(RdValid), .RdPC(RdPC),
        .RdState(RdState), .RdStamp(RdStamp), .Count(Count), .Frozen(Frozen), .Overflow(Overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input logic [63:0] pc, input logic [4:0] st, input bit rd);
        bit   lg = 0;
        bit   pp = 0;
        ent_t e;
        Reset = rst; PCIn = pc; StateIn = st; RdReq = rd;
        if (rst) begin
            m_q.delete(); sb_q.delete();
            m_mode = 0; m_pcnt = 0; m_primed = 0; m_ovf = 0; m_stq = '0; m_stamp = '0;
        end else begin
            lg = m_mode != 2 && (!m_primed || st != m_stq);
            pp = rd && m_q.size() > 0;
            if (pp) sb_q.push_back(m_q.pop_front());
            if (lg) begin
                if (m_q.size() == 16) begin
                    void'(m_q.pop_front());
                    m_ovf = 1;
                end
                m_q.push_back('{pc, st, m_stamp});
            end
            if (m_mode == 0 && lg && TrigEn && pc == TrigPC) begin
                m_mode = 1; m_pcnt = 8;
            end else if (m_mode == 1 && lg) begin
                m_pcnt--;
                if (m_pcnt == 0) m_mode = 2;
            end else if (m_mode == 2 && Rearm) begin
                m_mode = 0;
            end
            m_stq = st; m_primed = 1; m_stamp++;
        end
        @(posedge clk); #1;
        chk("rdvalid", 64'(RdValid), 64'(pp));
        if (pp) begin
            e = sb_q.pop_front();
            if (RdValid === 1'b1) begin
                chk("rdpc", RdPC, e.pc);
                chk("rdstate", 64'(RdState), 64'(e.st));
`ifdef PC_TRACE_STAMP_EN
                chk("rdstamp", 64'(RdStamp), 64'(e.stamp));
`else
                chk("rdstamp", 64'(RdStamp), 64'd0);
`endif
            end
        end
        chk("count", 64'(Count), 64'(m_q.size()));
        chk("frozen", 64'(Frozen), 64'(m_mode == 2));
        chk("overflow", 64'(Overflow), 64'(m_ovf));
    endtask

    initial begin
        // basic logging: states 0,0,1,2 then drain and one empty read
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 2, 0);
        chk("count_three", 64'(Count), 64'd3);
        for (int i = 0; i < 4; i++) step(0, 0, 2, 1);
        // fill to 16, then log+pop while full, then overwrite
        step(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 64'(i * 4), 5'(i % 5), 0);
        chk("count_full", 64'(Count), 64'd16);
        step(0, 64'h100, 5'd3, 1);
        chk("full_logpop_ovf", 64'(Overflow), 64'd0);
        step(0, 64'h104, 5'd4, 0);
        step(0, 64'h108, 5'd1, 0);
        step(0, 64'h10c, 5'd2, 0);
        chk("ovf_set", 64'(Overflow), 64'd1);
        for (int i = 0; i < 17; i++) step(0, 64'h10c, 5'd2, 1);
        // trigger at log event 5, eight post-trigger entries, freeze, rearm
        TrigEn = 1'b1; TrigPC = 64'h40;
        step(1, 0, 0, 0);
        for (int k = 1; k <= 20; k++) step(0, 64'((k - 1) * 16), 5'(k % 3), 0);
        chk("trig_count", 64'(Count), 64'd13);
        chk("trig_frozen", 64'(Frozen), 64'd1);
        TrigEn = 1'b0; Rearm = 1'b1;
        step(0, 64'h500, 5'd7, 0);
        Rearm = 1'b0;
        step(0, 64'h504, 5'd8, 0);
        step(0, 64'h508, 5'd9, 0);
        chk("rearm_count", 64'(Count), 64'd15);
        for (int i = 0; i < 3; i++) step(0, 64'h508, 5'd9, 1);
        // reset in the middle of the post-trigger window
        TrigEn = 1'b1;
        step(1, 0, 0, 0);
        for (int k = 1; k <= 10; k++) step(0, 64'((k - 1) * 16), 5'(k % 3), 0);
        chk("posttrig_count", 64'(Count), 64'd10);
        step(1, 64'h40, 5'd3, 1);
        TrigEn = 1'b0;
        chk("rst_count", 64'(Count), 64'd0);
        step(0, 64'h44, 5'd3, 1);
        step(0, 64'h44, 5'd3, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
